// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Shares the single-port unified RAM between instruction fetch (I)
//             and load/store (D), with registered per-port response slots.
//  Revision : 1.0  initial release
// ============================================================================

typedef enum logic [1:0] {
    MEM_BYTE     = 2'd0,
    MEM_HALFWORD = 2'd1,
    MEM_WORD     = 2'd2
} memory_mask_t;

module ram_arbiter #(
    parameter int ARB_MODE   = 0,
    parameter bit RESET_LAST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         i_req_valid,
    output logic         i_req_ready,
    input  logic [31:0]  i_req_addr,
    output logic         i_rsp_valid,
    output logic [31:0]  i_rsp_data,
    input  logic         i_rsp_ready,

    input  logic         d_req_valid,
    output logic         d_req_ready,
    input  logic         d_req_we,
    input  logic [31:0]  d_req_addr,
    input  logic [31:0]  d_req_wdata,
    input  memory_mask_t d_req_mask,
    output logic         d_rsp_valid,
    output logic [31:0]  d_rsp_data,
    input  logic         d_rsp_ready,

    output logic         ram_we,
    output logic [31:0]  ram_a,
    output logic [31:0]  ram_wd,
    output memory_mask_t ram_mask,
    input  logic [31:0]  ram_rd
);

    localparam bit c_fixed_prio = (ARB_MODE != 0);

    logic        r_last_grant;   // 1 = D was granted last
    logic        r_i_rsp_valid;
    logic [31:0] r_i_rsp_data;
    logic        r_d_rsp_valid;
    logic [31:0] r_d_rsp_data;

    logic w_i_elig;
    logic w_d_elig;
    logic w_grant_i;
    logic w_grant_d;

    // A full slot only accepts a new grant if it is being drained this cycle.
    always_comb begin
        w_i_elig  = i_req_valid && (!r_i_rsp_valid || i_rsp_ready);
        w_d_elig  = d_req_valid && (!r_d_rsp_valid || d_rsp_ready);
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (w_i_elig && w_d_elig) begin
            if (c_fixed_prio || !r_last_grant) begin
                w_grant_d = 1'b1;
            end else begin
                w_grant_i = 1'b1;
            end
        end else begin
            w_grant_i = w_i_elig;
            w_grant_d = w_d_elig;
        end
    end

    always_comb begin
        ram_we   = 1'b0;
        ram_a    = 32'd0;
        ram_wd   = 32'd0;
        ram_mask = MEM_WORD;
        if (w_grant_i) begin
            ram_a = i_req_addr;
        end else if (w_grant_d) begin
            ram_we   = d_req_we;
            ram_a    = d_req_addr;
            ram_wd   = d_req_wdata;
            ram_mask = d_req_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant  <= RESET_LAST;
            r_i_rsp_valid <= 1'b0;
            r_i_rsp_data  <= 32'd0;
            r_d_rsp_valid <= 1'b0;
            r_d_rsp_data  <= 32'd0;
        end else begin
            if (w_grant_i) begin
                r_last_grant  <= 1'b0;
                r_i_rsp_valid <= 1'b1;
                r_i_rsp_data  <= ram_rd;
            end else if (i_rsp_ready) begin
                r_i_rsp_valid <= 1'b0;
            end

            if (w_grant_d) begin
                r_last_grant  <= 1'b1;
                r_d_rsp_valid <= 1'b1;
                r_d_rsp_data  <= d_req_we ? 32'd0 : ram_rd;
            end else if (d_rsp_ready) begin
                r_d_rsp_valid <= 1'b0;
            end
        end
    end

    assign i_req_ready = w_grant_i;
    assign d_req_ready = w_grant_d;
    assign i_rsp_valid = r_i_rsp_valid;
    assign i_rsp_data  = r_i_rsp_data;
    assign d_rsp_valid = r_d_rsp_valid;
    assign d_rsp_data  = r_d_rsp_data;

endmodule

`default_nettype wire
